perf_event_counter: RTL and testbench
=====================================

Name: perf_event_counter

Overview:
- Parametrised hardware performance-counter unit for the pipelined CPU.
- Generalises the stall/flush tallying done in simulation into synthesizable RTL:
  - one free-running cycle counter;
  - NUM_CNT event counters, fed by CPU event strobes such as hazard stall, branch flush and instruction retire.
- Optional cycle limit ends the run.
- Results are read back through a registered select/read port.

Parameters:
- NUM_CNT, 4: number of event counters (1..15).
- CNT_W, 32: width of every counter (8..64).
- LIMIT, 0: cycle count at which the run ends; 0 = unlimited.
- SATURATE, 0: 0 = counters wrap at max; 1 = counters hold at 2^CNT_W-1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable (level); mirrors CPU start.
- clear_i  in  1  synchronous clear of all counters, overflow flags and FSM.
- freeze_i  in  1  pause counting without losing values.
- event_i  in  NUM_CNT  per-counter event strobes, 1 = count this cycle.
- rd_en_i  in  1  read request.
- rd_sel_i  in  4  counter select: 0..NUM_CNT-1 = event counters, NUM_CNT = cycle counter.
- rd_data_o  out  CNT_W  read data.
- rd_valid_o  out  1  read data valid.
- ovf_o  out  NUM_CNT+1  sticky overflow flags; bit NUM_CNT = cycle counter.
- done_o  out  1  high while in DONE.
- state_o  out  2  FSM state: IDLE=0, RUN=1, FROZEN=2, DONE=3.

Behaviour:
- Reset (rst_i=0, asynchronous), outputs and state:
  - state IDLE;
  - all counters 0;
  - ovf_o 0;
  - rd_data_o 0, rd_valid_o 0;
  - done_o 0.
- FSM, evaluated per edge, in priority order:
  - clear_i=1 (top priority): counters=0, ovf=0, state becomes IDLE.
  - IDLE: start_i=1 goes to RUN. No counting in the IDLE cycle itself.
  - RUN, count update:
    - cycle counter +1 every cycle;
    - counter k +1 when event_i[k]=1.
  - RUN, transitions, first match wins:
    - start_i=0 goes to IDLE, values held;
    - LIMIT!=0 and this edge's increment makes the cycle counter equal LIMIT goes to DONE;
    - freeze_i=1 goes to FROZEN.
  - The increment in the transitioning cycle is applied in every case.
  - FROZEN: no counting.
    - start_i=0 goes to IDLE;
    - freeze_i=0 returns to RUN.
  - DONE: no counting, done_o=1. Exit only via clear_i or reset; start_i is ignored.
- Arithmetic per counter:
  - SATURATE=0: increment from all-ones wraps to 0 and sets the ovf bit.
  - SATURATE=1: counter stays at all-ones and sets the ovf bit on every attempted increment at max.
  - ovf bits are sticky until clear_i or reset.
- Read port:
  - rd_en_i sampled at edge N gives rd_data_o and rd_valid_o=1 after edge N.
  - Data is the selected counter value as held before edge N (pre-increment, pre-clear).
  - rd_valid_o is 1 for exactly one cycle per request.
  - Back-to-back reads are allowed every cycle.
  - rd_sel_i > NUM_CNT returns 0 with rd_valid_o=1.
  - rd_data_o holds its last value when rd_en_i=0.
  - Reads are legal in every state.
- Reset mid-run: all state is lost immediately, outputs return to reset values.
- Simultaneous events:
  - all NUM_CNT strobes counted independently in the same cycle;
  - clear_i together with rd_en_i returns the pre-clear value.

Test Plan:
- Reset then start_i=1 for 10 cycles, event_i=4'b0001 every cycle -> cycle counter=10, counter0=10, others 0; read sel=4 gives 10 one cycle after rd_en_i.
- LIMIT=16, start_i held high, event_i[1] toggling -> done_o rises after edge 16; cycle counter=16, counter1=8; further edges change nothing; clear_i -> state_o=0, all counters 0.
- CNT_W=8, SATURATE=0, event_i[2]=1 for 257 RUN cycles -> counter2=1, ovf_o[2]=1. Same with SATURATE=1 -> counter2=255, ovf_o[2]=1.
- freeze_i=1 for 5 cycles mid-run, events active -> counters unchanged across the freeze; counting resumes the cycle after freeze_i=0.
- rd_en_i every cycle with sel=0 while event_i[0]=1 -> rd_data_o sequence lags the counter by one (0,1,2,...). sel=7 with NUM_CNT=4 -> rd_data_o=0, rd_valid_o=1.
- rst_i pulsed low asynchronously mid-cycle during RUN -> outputs zero immediately, state_o=0, no count on the next edge until start_i is seen.

Source files
------------

// File: rtl/perf_event_counter.sv
// -----------------------------------------------------------------------------
// perf_event_counter
//
// Hardware performance-counter unit. Holds one free-running cycle counter and
// NUM_CNT event counters fed by CPU event strobes. A small FSM
// (IDLE/RUN/FROZEN/DONE) gates counting. An optional cycle limit ends the run,
// and results are read through a registered select/read port.
//
// Parameters:
//   NUM_CNT  - number of event counters (1..15)
//   CNT_W    - width of every counter (8..64)
//   LIMIT    - cycle count at which the run ends (0 = unlimited)
//   SATURATE - 0: counters wrap at max, 1: counters hold at all-ones
//
// Ports:
//   clk_i      in   1          clock, rising edge
//   rst_i      in   1          asynchronous active-low reset
//   start_i    in   1          run enable (level)
//   clear_i    in   1          synchronous clear of counters, ovf flags, FSM
//   freeze_i   in   1          pause counting, values kept
//   event_i    in   NUM_CNT    per-counter event strobes
//   rd_en_i    in   1          read request
//   rd_sel_i   in   4          select: 0..NUM_CNT-1 event, NUM_CNT cycle
//   rd_data_o  out  CNT_W      registered read data
//   rd_valid_o out  1          read data valid (one cycle per request)
//   ovf_o      out  NUM_CNT+1  sticky overflow flags, MSB = cycle counter
//   done_o     out  1          high while in DONE
//   state_o    out  2          IDLE=0, RUN=1, FROZEN=2, DONE=3
// -----------------------------------------------------------------------------
module perf_event_counter #(
  parameter int NUM_CNT  = 4,
  parameter int CNT_W    = 32,
  parameter int LIMIT    = 0,
  parameter int SATURATE = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               freeze_i,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic               rd_en_i,
  input  logic [3:0]         rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic [NUM_CNT:0]   ovf_o,
  output logic               done_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(LIMIT);
  localparam bit               LIMIT_EN = (LIMIT != 0);
  localparam logic [3:0]       CYC_SEL  = 4'(NUM_CNT);

  // Returns {overflow, next_value} for one attempted increment.
  function automatic logic [CNT_W:0] incr(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (&v) begin
      if (SATURATE != 0) begin
        r = {1'b1, v};
      end else begin
        r = {1'b1, {CNT_W{1'b0}}};
      end
    end else begin
      r = {1'b0, v + {{(CNT_W-1){1'b0}}, 1'b1}};
    end
    return r;
  endfunction

  state_t             state_q;
  logic               done_q;
  logic [CNT_W-1:0]   cyc_q;
  logic [CNT_W-1:0]   cyc_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT:0]   ovf_q;
  logic [NUM_CNT:0]   ovf_d;
  logic [CNT_W-1:0]   rd_data_q;
  logic               rd_valid_q;

  logic               count_en_s;
  logic               limit_hit_s;
  logic [CNT_W:0]     cyc_inc_s;
  logic [CNT_W:0]     cnt_inc_s [NUM_CNT];
  logic [CNT_W-1:0]   rd_mux_s;

  assign count_en_s = (state_q == ST_RUN);

  // Next-state values for the counters and overflow flags.
  always_comb begin
    cyc_inc_s = incr(cyc_q);
    cyc_d     = cyc_q;
    ovf_d     = ovf_q;
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_inc_s[k] = incr(cnt_q[k]);
      cnt_d[k]     = cnt_q[k];
    end
    if (count_en_s) begin
      cyc_d          = cyc_inc_s[CNT_W-1:0];
      ovf_d[NUM_CNT] = ovf_q[NUM_CNT] | cyc_inc_s[CNT_W];
      for (int k = 0; k < NUM_CNT; k++) begin
        if (event_i[k]) begin
          cnt_d[k] = cnt_inc_s[k][CNT_W-1:0];
          ovf_d[k] = ovf_q[k] | cnt_inc_s[k][CNT_W];
        end else begin
          cnt_d[k] = cnt_q[k];
        end
      end
    end else begin
      cyc_d = cyc_q;
    end
  end

  // The limit is judged on the value this edge's increment produces.
  assign limit_hit_s = LIMIT_EN && count_en_s && (cyc_d == LIMIT_C);

  // Read select mux; out-of-range selects read as zero.
  always_comb begin
    rd_mux_s = '0;
    if (rd_sel_i == CYC_SEL) begin
      rd_mux_s = cyc_q;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (rd_sel_i == 4'(k)) begin
          rd_mux_s = cnt_q[k];
        end else begin
          rd_mux_s = rd_mux_s;
        end
      end
    end
  end

  // Run-control FSM with registered done flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!start_i) begin
            state_q <= ST_IDLE;
          end else if (limit_hit_s) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (freeze_i) begin
            state_q <= ST_FROZEN;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_FROZEN: begin
          if (!start_i) begin
            state_q <= ST_IDLE;
          end else if (!freeze_i) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_FROZEN;
          end
        end
        ST_DONE: begin
          // Sticky until clear or reset; start is ignored here.
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Counter and overflow flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q <= '0;
      ovf_q <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (clear_i) begin
      cyc_q <= '0;
      ovf_q <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cyc_q <= cyc_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Registered read port; it captures pre-edge values, so it is left
  // untouched by clear and returns the pre-clear value on a combined request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_mux_s;
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ovf_o      = ovf_q;
  assign done_o     = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_perf_event_counter.sv
module tb_perf_event_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] ev = 4'd0;
  logic       rd_en = 1'b0;
  logic [3:0] sel = 4'd0;

  always #5 clk = ~clk;

  // Four instances: default, LIMIT=16, 8-bit wrap, 8-bit saturate
  logic [31:0] rd_a, rd_l;
  logic [7:0]  rd_w, rd_s;
  logic        vld_a, vld_l, vld_w, vld_s;
  logic [4:0]  ovf_a, ovf_l, ovf_w, ovf_s;
  logic        done_a, done_l, done_w, done_s;
  logic [1:0]  st_a, st_l, st_w, st_s;

  perf_event_counter #(.NUM_CNT(4), .CNT_W(32), .LIMIT(0), .SATURATE(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
    .event_i(ev), .rd_en_i(rd_en), .rd_sel_i(sel), .rd_data_o(rd_a),
    .rd_valid_o(vld_a), .ovf_o(ovf_a), .done_o(done_a), .state_o(st_a));
  perf_event_counter #(.NUM_CNT(4), .CNT_W(32), .LIMIT(16), .SATURATE(0)) dut_l (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
    .event_i(ev), .rd_en_i(rd_en), .rd_sel_i(sel), .rd_data_o(rd_l),
    .rd_valid_o(vld_l), .ovf_o(ovf_l), .done_o(done_l), .state_o(st_l));
  perf_event_counter #(.NUM_CNT(4), .CNT_W(8), .LIMIT(0), .SATURATE(0)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
    .event_i(ev), .rd_en_i(rd_en), .rd_sel_i(sel), .rd_data_o(rd_w),
    .rd_valid_o(vld_w), .ovf_o(ovf_w), .done_o(done_w), .state_o(st_w));
  perf_event_counter #(.NUM_CNT(4), .CNT_W(8), .LIMIT(0), .SATURATE(1)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .freeze_i(freeze),
    .event_i(ev), .rd_en_i(rd_en), .rd_sel_i(sel), .rd_data_o(rd_s),
    .rd_valid_o(vld_s), .ovf_o(ovf_s), .done_o(done_s), .state_o(st_s));

  // Observed vector per instance: {state, done, ovf, valid, data(64)}
  logic [72:0] o_vec [4];
  assign o_vec[0] = {st_a, done_a, ovf_a, vld_a, 32'd0, rd_a};
  assign o_vec[1] = {st_l, done_l, ovf_l, vld_l, 32'd0, rd_l};
  assign o_vec[2] = {st_w, done_w, ovf_w, vld_w, 56'd0, rd_w};
  assign o_vec[3] = {st_s, done_s, ovf_s, vld_s, 56'd0, rd_s};

  int total = 0;
  int bad = 0;

  // Behavioural reference model (one per instance)
  int     p_w   [4] = '{32, 32, 8, 8};
  int     p_lim [4] = '{0, 16, 0, 0};
  int     p_sat [4] = '{0, 0, 0, 1};
  longint m_cnt [4][4];
  longint m_cyc [4];
  bit [4:0] m_ovf [4];
  int     m_st  [4];   // 0 idle, 1 run, 2 frozen, 3 done
  longint m_rdata [4];
  bit     m_rvalid [4];

  function automatic longint bump(input longint v, input int w, input int sat, output bit o);
    longint mx;
    mx = (longint'(1) << w) - 1;
    o = 1'b0;
    if (v == mx) begin
      o = 1'b1;
      return (sat != 0) ? mx : 0;
    end
    return v + 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
      m_cyc[d] = 0; m_ovf[d] = 5'd0; m_st[d] = 0;
      m_rdata[d] = 0; m_rvalid[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit o;
    for (int d = 0; d < 4; d++) begin
      if (rd_en) begin
        m_rvalid[d] = 1'b1;
        if (sel < 4) m_rdata[d] = m_cnt[d][sel];
        else if (sel == 4) m_rdata[d] = m_cyc[d];
        else m_rdata[d] = 0;
      end else begin
        m_rvalid[d] = 1'b0;
      end
      if (clear) begin
        for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
        m_cyc[d] = 0; m_ovf[d] = 5'd0; m_st[d] = 0;
      end else begin
        case (m_st[d])
          0: if (start) m_st[d] = 1;
          1: begin
            m_cyc[d] = bump(m_cyc[d], p_w[d], p_sat[d], o);
            if (o) m_ovf[d][4] = 1'b1;
            for (int k = 0; k < 4; k++) begin
              if (ev[k]) begin
                m_cnt[d][k] = bump(m_cnt[d][k], p_w[d], p_sat[d], o);
                if (o) m_ovf[d][k] = 1'b1;
              end
            end
            if (!start) m_st[d] = 0;
            else if (p_lim[d] != 0 && m_cyc[d] == p_lim[d]) m_st[d] = 3;
            else if (freeze) m_st[d] = 2;
          end
          2: begin
            if (!start) m_st[d] = 0;
            else if (!freeze) m_st[d] = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; rd_en = 1'b0; start = 1'b0; freeze = 1'b0; ev = 4'd0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [72:0] e;
    rst = 1'b0;
    model_reset();
    #12;
    for (int d = 0; d < 4; d++) begin
      e = {m_st[d][1:0], m_st[d] == 3, m_ovf[d], m_rvalid[d], m_rdata[d]};
      total++;
      if (o_vec[d] !== e || o_vec[d] !== 73'd0) begin
        bad++; $display("FAIL reset dut%0d got=%h exp=%h", d, o_vec[d], e);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [72:0] e;
    do_clear();
    start = 1'b1; ev = 4'b0001;
    for (int t = 0; t < 11; t++) tick();
    rd_en = 1'b1; sel = 4'd4;
    tick();
    total++;
    if (rd_a !== 32'd10 || vld_a !== 1'b1) begin
      bad++; $display("FAIL basic_cyc got=%0d/%0b exp=10/1", rd_a, vld_a);
    end
    start = 1'b0; ev = 4'd0; sel = 4'd1;
    tick();
    rd_en = 1'b0;
    for (int d = 0; d < 4; d++) begin
      e = {m_st[d][1:0], m_st[d] == 3, m_ovf[d], m_rvalid[d], m_rdata[d]};
      total++;
      if (o_vec[d] !== e) begin
        bad++; $display("FAIL basic dut%0d got=%h exp=%h", d, o_vec[d], e);
      end
    end
  endtask

  task automatic test_limit();
    logic [72:0] e;
    do_clear();
    start = 1'b1;
    for (int i = 0; i < 22; i++) begin
      ev = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      tick();
      for (int d = 0; d < 4; d++) begin
        e = {m_st[d][1:0], m_st[d] == 3, m_ovf[d], m_rvalid[d], m_rdata[d]};
        total++;
        if (o_vec[d] !== e) begin
          bad++; $display("FAIL limit dut%0d i=%0d got=%h exp=%h", d, i, o_vec[d], e);
        end
      end
    end
    rd_en = 1'b1; sel = 4'd4;
    tick();
    total++;
    if (rd_l !== 32'd16 || done_l !== 1'b1 || st_l !== 2'd3) begin
      bad++; $display("FAIL limit_cyc got=%0d done=%0b st=%0d exp=16/1/3", rd_l, done_l, st_l);
    end
    sel = 4'd1;
    tick();
    total++;
    if (rd_l !== 32'd8) begin
      bad++; $display("FAIL limit_cnt1 got=%0d exp=8", rd_l);
    end
    do_clear();
    rd_en = 1'b1; sel = 4'd4;
    tick();
    rd_en = 1'b0;
    total++;
    if (st_l !== 2'd0 || done_l !== 1'b0 || rd_l !== 32'd0) begin
      bad++; $display("FAIL limit_clear st=%0d done=%0b cyc=%0d exp=0/0/0", st_l, done_l, rd_l);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    start = 1'b1; ev = 4'b0100;
    for (int t = 0; t < 258; t++) tick();
    rd_en = 1'b1; sel = 4'd2;
    tick();
    rd_en = 1'b0; start = 1'b0; ev = 4'd0;
    total++;
    if (rd_w !== 8'd1 || ovf_w[2] !== 1'b1) begin
      bad++; $display("FAIL wrap got=%0d ovf=%0b exp=1/1", rd_w, ovf_w[2]);
    end
    total++;
    if (rd_s !== 8'd255 || ovf_s[2] !== 1'b1) begin
      bad++; $display("FAIL saturate got=%0d ovf=%0b exp=255/1", rd_s, ovf_s[2]);
    end
    total++;
    if (rd_a !== 32'd257 || ovf_a !== 5'd0) begin
      bad++; $display("FAIL wide_no_wrap got=%0d ovf=%h exp=257/0", rd_a, ovf_a);
    end
  endtask

  task automatic test_freeze();
    logic [72:0] e;
    do_clear();
    start = 1'b1; ev = 4'b1111; rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      freeze = (i >= 6 && i < 11);
      sel = 4'(i % 5);
      tick();
      for (int d = 0; d < 4; d++) begin
        e = {m_st[d][1:0], m_st[d] == 3, m_ovf[d], m_rvalid[d], m_rdata[d]};
        total++;
        if (o_vec[d] !== e) begin
          bad++; $display("FAIL freeze dut%0d i=%0d got=%h exp=%h", d, i, o_vec[d], e);
        end
      end
    end
    rd_en = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [72:0] e;
    do_clear();
    start = 1'b1; ev = 4'b0001; rd_en = 1'b1; sel = 4'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        e = {m_st[d][1:0], m_st[d] == 3, m_ovf[d], m_rvalid[d], m_rdata[d]};
        total++;
        if (o_vec[d] !== e) begin
          bad++; $display("FAIL b2b dut%0d i=%0d got=%h exp=%h", d, i, o_vec[d], e);
        end
      end
    end
    sel = 4'd7;
    tick();
    total++;
    if (rd_a !== 32'd0 || vld_a !== 1'b1) begin
      bad++; $display("FAIL sel7 got=%0d/%0b exp=0/1", rd_a, vld_a);
    end
    sel = 4'd0;
    tick();
    rd_en = 1'b0;
    tick();
    total++;
    if (vld_a !== 1'b0 || rd_a !== 32'd12) begin
      bad++; $display("FAIL rd_hold got=%0d/%0b exp=12/0", rd_a, vld_a);
    end
  endtask

  task automatic test_random();
    logic [72:0] e;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      clear  = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 9) != 0);
      freeze = ($urandom_range(0, 4) == 0);
      ev     = 4'($urandom_range(0, 15));
      rd_en  = ($urandom_range(0, 1) == 1);
      sel    = 4'($urandom_range(0, 7));
      tick();
      for (int d = 0; d < 4; d++) begin
        e = {m_st[d][1:0], m_st[d] == 3, m_ovf[d], m_rvalid[d], m_rdata[d]};
        total++;
        if (o_vec[d] !== e) begin
          bad++; $display("FAIL random dut%0d i=%0d got=%h exp=%h", d, i, o_vec[d], e);
        end
      end
    end
    clear = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [72:0] e;
    do_clear();
    start = 1'b1; ev = 4'b1111; rd_en = 1'b1; sel = 4'd4;
    for (int t = 0; t < 6; t++) tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (o_vec[d] !== 73'd0) begin
        bad++; $display("FAIL async_rst dut%0d got=%h exp=0", d, o_vec[d]);
      end
    end
    @(posedge clk);
    #3 rst = 1'b1;
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = (i == 2);
      tick();
      for (int d = 0; d < 4; d++) begin
        e = {m_st[d][1:0], m_st[d] == 3, m_ovf[d], m_rvalid[d], m_rdata[d]};
        total++;
        if (o_vec[d] !== e) begin
          bad++; $display("FAIL post_rst dut%0d i=%0d got=%h exp=%h", d, i, o_vec[d], e);
        end
      end
    end
    // One IDLE edge then one RUN edge: the cycle counter read is 1
    total++;
    if (rd_a !== 32'd1) begin
      bad++; $display("FAIL post_rst_cyc got=%0d exp=1", rd_a);
    end
    rd_en = 1'b0; start = 1'b0; ev = 4'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit();
    test_wrap();
    test_freeze();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
